// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter feeding a single register-file write port
module wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_dest,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 reg_write_enable,
    output logic [4:0]           write_addr,
    output logic [31:0]          write_data,
    output logic [7:0]           wb_stall_cnt
);

    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_we;
    logic [4:0]       r_addr;
    logic [31:0]      r_data;
    logic [7:0]       r_stall_cnt;

    logic [PTR_W-1:0] w_start;
    logic [PTR_W-1:0] w_grant_idx;
    logic [PTR_W-1:0] w_next_ptr;
    logic             w_found;
    logic             w_multi;
    logic [NREQ-1:0]  w_grant;
    logic [4:0]       w_dest;
    logic [31:0]      w_data;

    // Two ascending passes: first from the pointer upward, then wrap to index 0.
    always_comb begin : p_search
        int n_valid;
        w_start     = (int'(r_rr_ptr) >= NREQ) ? '0 : r_rr_ptr;
        w_found     = 1'b0;
        w_grant_idx = '0;
        n_valid     = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(w_start))) begin
                w_found     = 1'b1;
                w_grant_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found     = 1'b1;
                w_grant_idx = PTR_W'(i);
            end
            if (req_valid[i]) begin
                n_valid = n_valid + 1;
            end
        end
        w_multi = (n_valid > 1);
    end

    always_comb begin
        w_grant = '0;
        w_dest  = '0;
        w_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_grant[i] = w_found & rst;
                w_dest     = req_dest[5*i +: 5];
                w_data     = req_data[32*i +: 32];
            end
        end
        w_next_ptr = (int'(w_grant_idx) == NREQ - 1) ? '0 : w_grant_idx + 1'b1;
    end

    assign req_ready        = w_grant;
    assign reg_write_enable = r_we;
    assign write_addr       = r_addr;
    assign write_data       = r_data;
    assign wb_stall_cnt     = r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_found) begin
                r_rr_ptr <= w_next_ptr;
                // Writes to x0 are consumed but never reach the register file.
                if (w_dest != 5'd0) begin
                    r_we   <= 1'b1;
                    r_addr <= w_dest;
                    r_data <= w_data;
                end else begin
                    r_we   <= 1'b0;
                    r_addr <= '0;
                    r_data <= '0;
                end
            end else begin
                r_we <= 1'b0;
            end
            if (w_multi && (r_stall_cnt != 8'hFF)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_dest;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        reg_write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [7:0]  wb_stall_cnt;

    int n_pass;
    int n_total;

    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt;

    typedef struct packed {
        logic        rst_first;
        logic [2:0]  v;
        logic [14:0] dest;
        logic [95:0] data;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [13];

    wb_arbiter #(.NREQ(3), .PTR_W(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_dest         (req_dest),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .reg_write_enable (reg_write_enable),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .wb_stall_cnt     (wb_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int pick(input logic [2:0] v, input int p);
        int s;
        int idx;
        s = (p >= 3) ? 0 : p;
        for (int off = 0; off < 3; off++) begin
            idx = (s + off) % 3;
            if (((v >> idx) & 3'b001) != 3'b000) return idx;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_ready(input logic [2:0] v);
        int k;
        k = pick(v, m_ptr);
        return (k < 0) ? 3'b000 : 3'(1 << k);
    endfunction

    task automatic model_step(input logic [2:0] v, input logic [14:0] d, input logic [95:0] x);
        int k;
        logic [4:0] dk;
        k = pick(v, m_ptr);
        if (k >= 0) begin
            dk = 5'(d >> (5 * k));
            if (dk != 5'd0) begin
                m_we   = 1'b1;
                m_addr = dk;
                m_data = 32'(x >> (32 * k));
            end else begin
                m_we   = 1'b0;
                m_addr = 5'd0;
                m_data = 32'd0;
            end
            m_ptr = (k + 1) % 3;
        end else begin
            m_we = 1'b0;
        end
        if ($countones(v) > 1 && m_cnt < 255) m_cnt++;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        req_valid = 3'b111;
        req_dest  = {5'd1, 5'd2, 5'd3};
        req_data  = {32'h1, 32'h2, 32'h3};
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we", 32'(reg_write_enable), 32'd0);
        chk("rst_addr", 32'(write_addr), 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_cnt", 32'(wb_stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 3'b000;
        model_reset();
    endtask

    task automatic cycle(input logic [2:0] v, input logic [14:0] d, input logic [95:0] x);
        req_valid = v;
        req_dest  = d;
        req_data  = x;
        #1;
        chk("ready", 32'(req_ready), 32'(model_ready(v)));
        @(posedge clk);
        model_step(v, d, x);
        #1;
        chk("we", 32'(reg_write_enable), 32'(m_we));
        chk("addr", 32'(write_addr), 32'(m_addr));
        chk("data", write_data, m_data);
        chk("cnt", 32'(wb_stall_cnt), 32'(m_cnt));
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b0;
        req_valid = 3'b000;
        req_dest  = '0;
        req_data  = '0;
        model_reset();

        tbl[0]  = '{1'b1, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 8'd0};
        tbl[1]  = '{1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 3'b001, 1'b1, 5'd1, 32'hA, 8'd1};
        tbl[2]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 3'b010, 1'b1, 5'd2, 32'hB, 8'd2};
        tbl[3]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 3'b100, 1'b1, 5'd3, 32'hC, 8'd3};
        tbl[4]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 3'b001, 1'b1, 5'd1, 32'hA, 8'd4};
        tbl[5]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 3'b010, 1'b1, 5'd2, 32'hB, 8'd5};
        tbl[6]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 3'b100, 1'b1, 5'd3, 32'hC, 8'd6};
        tbl[7]  = '{1'b0, 3'b100, {5'd0, 5'd7, 5'd7}, {32'h12345678, 32'h1, 32'h1}, 3'b100, 1'b0, 5'd0, 32'h0, 8'd6};
        tbl[8]  = '{1'b0, 3'b000, {5'd9, 5'd9, 5'd9}, {32'h9, 32'h9, 32'h9}, 3'b000, 1'b0, 5'd0, 32'h0, 8'd6};
        tbl[9]  = '{1'b0, 3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99}, 3'b001, 1'b1, 5'd9, 32'h99, 8'd6};
        tbl[10] = '{1'b0, 3'b101, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 3'b100, 1'b1, 5'd4, 32'h44, 8'd7};
        tbl[11] = '{1'b0, 3'b101, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 3'b001, 1'b1, 5'd6, 32'h66, 8'd8};
        tbl[12] = '{1'b0, 3'b000, {5'd1, 5'd1, 5'd1}, {32'h5, 32'h5, 32'h5}, 3'b000, 1'b0, 5'd6, 32'h66, 8'd8};

        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst_first) do_reset();
            req_valid = tbl[i].v;
            req_dest  = tbl[i].dest;
            req_data  = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].dest, tbl[i].data);
            #1;
            chk($sformatf("tbl%0d_we", i), 32'(reg_write_enable), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_addr", i), 32'(write_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_data", i), write_data, tbl[i].wdata);
            chk($sformatf("tbl%0d_cnt", i), 32'(wb_stall_cnt), 32'(tbl[i].cnt));
        end

        // Stall counter saturation with two requesters contending.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(3'b011, {5'd0, 5'd2, 5'd1}, {32'h0, 32'hB0B, 32'hA0A});
            if (i == 253) chk("sat_254", 32'(wb_stall_cnt), 32'd254);
            if (i == 254) chk("sat_255", 32'(wb_stall_cnt), 32'd255);
        end
        chk("sat_hold", 32'(wb_stall_cnt), 32'd255);

        // Reset asserted in the middle of an accepted transfer.
        do_reset();
        cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
        cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
        req_valid = 3'b111;
        #1;
        chk("mid_ready_pre", 32'(req_ready), 32'b100);
        rst = 1'b0;
        #1;
        chk("mid_ready", 32'(req_ready), 32'd0);
        chk("mid_we", 32'(reg_write_enable), 32'd0);
        chk("mid_addr", 32'(write_addr), 32'd0);
        chk("mid_data", write_data, 32'd0);
        chk("mid_cnt", 32'(wb_stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cycle(3'b000, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
        chk("post_rst_no_write", 32'(reg_write_enable), 32'd0);
        cycle(3'b110, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
        chk("post_rst_first_addr", 32'(write_addr), 32'd2);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [14:0] d;
            logic [95:0] x;
            for (int j = 0; j < 3; j++) begin
                d[5*j +: 5]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                x[32*j +: 32] = $urandom;
            end
            cycle(3'($urandom_range(0, 7)), d, x);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write-back requesters (index 0 = ALU, 1 = LSU load, 2 = MDU).
REQ-002 SHALL have parameter PTR_W, default 2, width of the round-robin pointer, ceil(log2(NREQ)).
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset; asserting rst low immediately forces reset state.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester "write-back pending" flags.
REQ-006 SHALL have port req_dest, input, 5*NREQ, per-requester destination register; requester i occupies bits [5i+4:5i].
REQ-007 SHALL have port req_data, input, 32*NREQ, per-requester write data; requester i occupies bits [32i+31:32i].
REQ-008 SHALL have port req_ready, output, NREQ, one-hot grant indicating the request is accepted this cycle.
REQ-009 SHALL have port reg_write_enable, output, 1, register-file write strobe.
REQ-010 SHALL have port write_addr, output, 5, register-file write address.
REQ-011 SHALL have port write_data, output, 32, register-file write data.
REQ-012 SHALL have port wb_stall_cnt, output, 8, saturating count of cycles in which at least one valid requester was not granted.

Function
REQ-013 SHALL accept requester i on a cycle iff req_valid[i] and req_ready[i] are both 1 (a transfer).
REQ-014 SHALL drive req_ready combinationally, at most one bit set, and set only for a requester whose req_valid is 1.
REQ-015 SHALL grant round-robin: search starts at index rr_ptr, ascending modulo NREQ; first valid index wins.
REQ-016 SHALL, on a transfer by index k, load rr_ptr with (k+1) mod NREQ at the next edge; with no transfer, rr_ptr SHALL hold.
REQ-017 SHALL grant every cycle in which any req_valid is 1; the register-file write port never back-pressures.
REQ-018 SHALL register the accepted transfer, so that reg_write_enable, write_addr and write_data present it exactly 1 cycle after acceptance.
REQ-019 SHALL, on a cycle with no transfer, drive reg_write_enable to 0 on the next cycle while holding write_addr and write_data.
REQ-020 SHALL treat dest 0 as a valid transfer (req_ready asserted, rr_ptr advances), but the registered output SHALL show reg_write_enable=0, write_addr=0, write_data=0.
REQ-021 SHALL allow requesters to drop or change req_valid, req_dest or req_data in any cycle without a transfer; only transferred values are used.
REQ-022 SHALL increment wb_stall_cnt by 1 on each cycle where popcount(req_valid) > 1, and saturate at 255.
REQ-023 SHALL treat rr_ptr values >= NREQ as 0 for the search, so that only reachable states are used.

Reset
REQ-024 SHALL, while rst = 0, force the following: reg_write_enable=0, write_addr=0, write_data=0, rr_ptr=0, wb_stall_cnt=0.
REQ-025 SHALL force req_ready to all-zero while rst = 0, regardless of req_valid.
REQ-026 SHALL discard a transfer accepted in the cycle rst asserts; no write SHALL appear after reset is released.
REQ-027 SHALL resume arbitration on the first rising edge after rst returns to 1, starting the search at index 0.

Verification
REQ-028 SHALL cover the single-requester case: req_valid=3'b010, dest=5, data=0xDEADBEEF -> req_ready=3'b010 the same cycle; next cycle reg_write_enable=1, write_addr=5, write_data=0xDEADBEEF.
REQ-029 SHALL cover round-robin order: req_valid=3'b111 held for 6 cycles from reset -> grants 0,1,2,0,1,2 in order; wb_stall_cnt=6.
REQ-030 SHALL cover the x0 write: requester 2 with dest=0, data=0x12345678 -> req_ready[2]=1; next cycle reg_write_enable=0, write_addr=0, write_data=0.
REQ-031 SHALL cover pointer skip: rr_ptr=1 with req_valid=3'b101 -> grant index 2, then rr_ptr=0, then grant index 0.
REQ-032 SHALL cover stall-counter saturation: two requesters valid for 300 cycles -> wb_stall_cnt=255 and holds at 255.
REQ-033 SHALL cover reset mid-operation: rst pulsed low during a transfer -> all outputs 0 asynchronously; after release, the first grant goes to the lowest valid index.
